serial_mag_comp: RTL and testbench



---
 rtl/serial_mag_comp.sv | 108 ++++++++++
 tb/tb_serial_mag_comp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp.sv
// serial_mag_comp
//   Folds a stream of per-bit compare codes (eq/lt/gt, MSB first) into a
//   full-word magnitude result. The first legal non-equal bit locks the
//   answer. Once WIDTH bits have been accepted, done pulses for one cycle and
//   res_* show the word result. res_* then hold until the next word completes.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               begin a new word (an abort if a word is in flight)
//   bit_valid           bit_eq/bit_lt/bit_gt carry a code this cycle
//   bit_eq/lt/gt        per-bit compare code from the 1-bit comparator
//   busy                a word is being accumulated (RUN)
//   done                one-cycle pulse; res_*/err just updated
//   res_eq/lt/gt        word result; exactly one is high after a word
//   err                 sticky flag: an illegal code was seen in this word
//   bit_cnt             bits accepted in the current word
module serial_mag_comp #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_eq,
  input  logic             bit_lt,
  input  logic             bit_gt,
  output logic             busy,
  output logic             done,
  output logic             res_eq,
  output logic             res_lt,
  output logic             res_gt,
  output logic             err,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t state, state_n;
  logic   lock, lock_gt;
  logic   lock_n, lock_gt_n;
  logic   accept, legal, last;

  // A bit is taken only in RUN. A start in the same cycle wins, and that
  // cycle's bit is dropped.
  assign accept = (state == RUN) && bit_valid && !start;
  // A legal code has exactly one line high: the count of high lines is odd
  // and not three.
  assign legal  = (bit_eq ^ bit_lt ^ bit_gt) & ~(bit_eq & bit_lt & bit_gt);
  assign last   = accept && (bit_cnt == CNT_W'(WIDTH-1));
  assign busy   = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    lock_n    = lock;
    lock_gt_n = lock_gt;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (!start && last) state_n = HOLD;
      HOLD:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
    // The first legal non-equal bit decides the word. Later bits cannot
    // change the decision.
    if (!lock && legal && (bit_lt || bit_gt)) begin
      lock_n    = 1'b1;
      lock_gt_n = bit_gt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      res_eq  <= 1'b0;
      res_lt  <= 1'b0;
      res_gt  <= 1'b0;
      err     <= 1'b0;
      bit_cnt <= '0;
      lock    <= 1'b0;
      lock_gt <= 1'b0;
    end else begin
      done <= last;
      if (start) begin
        bit_cnt <= '0;
        lock    <= 1'b0;
        lock_gt <= 1'b0;
        err     <= 1'b0;
      end else if (accept) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        lock    <= lock_n;
        lock_gt <= lock_gt_n;
        if (!legal) err <= 1'b1;
        // The result uses the lock value that includes the final bit.
        if (last) begin
          res_eq <= ~lock_n;
          res_gt <= lock_n & lock_gt_n;
          res_lt <= lock_n & ~lock_gt_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
module tb_serial_mag_comp;
  localparam int W  = 4;
  localparam int CW = $clog2(W+1);
  localparam logic [2:0] E = 3'b100, L = 3'b010, G = 3'b001;

  logic clk = 0, rst = 1;
  logic start = 0, bit_valid = 0, bit_eq = 0, bit_lt = 0, bit_gt = 0;
  logic busy, done, res_eq, res_lt, res_gt, err;
  logic [CW-1:0] bit_cnt;

  serial_mag_comp #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .bit_eq(bit_eq), .bit_lt(bit_lt), .bit_gt(bit_gt),
    .busy(busy), .done(done), .res_eq(res_eq), .res_lt(res_lt),
    .res_gt(res_gt), .err(err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [3:0] q[$];  // expected {eq,lt,gt,err} per completed word

  typedef struct {
    logic [0:3][2:0] c;
    bit              gap;
    logic [3:0]      e;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard side: each done pops one expected word result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        logic [3:0] e;
        e = q.pop_front();
        chk("word_result", {res_eq, res_lt, res_gt, err}, e);
        chk("done_bit_cnt", bit_cnt, W);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [2:0] c);
    start = s; bit_valid = v; {bit_eq, bit_lt, bit_gt} = c;
  endtask

  task automatic do_start();
    drive(1, 0, 3'b000); tick();
    drive(0, 0, 3'b000);
    chk("start_busy", busy, 1);
    chk("start_cnt", bit_cnt, 0);
  endtask

  // Ends in the done cycle, with the inputs idle.
  task automatic send_bits(input logic [0:3][2:0] c, input bit gap, input logic [3:0] e);
    for (int i = 0; i < W; i++) begin
      if (gap) begin
        drive(0, 0, c[i]); tick();
        chk("gap_busy", busy, 1);
        chk("gap_cnt", bit_cnt, i);
      end
      drive(0, 1, c[i]);
      if (i == W-1) q.push_back(e);
      tick();
      if (i < W-1) begin
        chk("run_cnt", bit_cnt, i+1);
        chk("run_nodone", done, 0);
      end
    end
    drive(0, 0, 3'b000);
    chk("done_latency", done, 1);
    chk("hold_busy", busy, 0);
  endtask

  initial begin
    tbl[0] = '{{E, E, G, E}, 1'b0, 4'b0010};            // 1011 vs 1001
    tbl[1] = '{{E, E, E, E}, 1'b1, 4'b1000};            // 0110 vs 0110, stretched
    tbl[2] = '{{L, G, L, L}, 1'b0, 4'b0100};            // 0100 vs 1011
    tbl[3] = '{{E, E, 3'b101, E}, 1'b0, 4'b1001};       // illegal third code
    tbl[4] = '{{E, E, E, E}, 1'b0, 4'b1000};            // err cleared next word
    tbl[5] = '{{E, G, L, E}, 1'b0, 4'b0010};
    tbl[6] = '{{3'b000, L, E, E}, 1'b0, 4'b0101};       // illegal, then lock lt
    tbl[7] = '{{G, 3'b111, E, E}, 1'b1, 4'b0011};

    #2;
    chk("rst_outs", {busy, done, res_eq, res_lt, res_gt, err}, 6'b0);
    chk("rst_cnt", bit_cnt, 0);
    tick(); tick();
    rst = 0;
    tick();

    foreach (tbl[k]) begin
      do_start();
      send_bits(tbl[k].c, tbl[k].gap, tbl[k].e);
      tick();
      chk("done_pulse", done, 0);
      chk("hold_res", {res_eq, res_lt, res_gt, err}, tbl[k].e);
      chk("hold_cnt", bit_cnt, W);
    end

    // Bits are ignored while in HOLD.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, L); tick();
      chk("hold_ignore_cnt", bit_cnt, W);
      chk("hold_ignore_busy", busy, 0);
    end
    chk("hold_ignore_res", {res_eq, res_lt, res_gt}, 3'b001);

    // Abort: two bits, then a restart, then a full word.
    do_start();
    drive(0, 1, E); tick();
    drive(0, 1, G); tick();
    chk("abort_pre_cnt", bit_cnt, 2);
    drive(1, 1, L); tick();
    chk("abort_cnt", bit_cnt, 0);
    chk("abort_busy", busy, 1);
    chk("abort_res", {res_eq, res_lt, res_gt}, 3'b001);
    send_bits({E, E, E, L}, 1'b0, 4'b0100);
    tick();

    // A start in the done cycle: done still pulses, and the bit is discarded.
    do_start();
    send_bits({G, E, E, E}, 1'b0, 4'b0010);
    drive(1, 1, L); tick();
    chk("coinc_done", done, 0);
    chk("coinc_busy", busy, 1);
    chk("coinc_cnt", bit_cnt, 0);
    chk("coinc_res", {res_eq, res_lt, res_gt}, 3'b001);
    send_bits({E, E, E, E}, 1'b0, 4'b1000);
    tick();

    // Reset mid-word: an illegal bit sets err first, so the reset must clear it.
    do_start();
    drive(0, 1, 3'b000); tick();
    drive(0, 1, G); tick();
    chk("pre_rst_err", err, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_outs", {busy, done, res_eq, res_lt, res_gt, err}, 6'b0);
    chk("mid_rst_cnt", bit_cnt, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, G); tick();
      chk("idle_cnt", bit_cnt, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
    drive(0, 0, 3'b000);
    tick(); tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
